// File: rtl/sram_arbiter_pkg.sv
// Shared constants, width helper and the per-port request record for the
// arbitrated multi-bank SRAM.
package mem_pkg;

  localparam int BANK_WORDS = 256;
  localparam int BANK_AW    = 8;

  // Request record fields are sized for the widest supported port; the top
  // level narrows them back to its own ADDR_W / DATA_W.
  localparam int REQ_AW_MAX = 32;
  localparam int REQ_DW_MAX = 32;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  typedef struct packed {
    logic                  we;
    logic [REQ_AW_MAX-1:0] addr;
    logic [REQ_DW_MAX-1:0] wdata;
  } port_req_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requestor-side bus of the arbitrated SRAM: per-port request lanes plus the
// shared read data return.
interface sram_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16
);
  // Handshake: a port raises req with we/addr/wdata and holds them stable until
  // it sees gnt in the same cycle; the access is taken at the edge where
  // req & gnt. A read returns rvalid (one-hot) with rdata exactly one cycle
  // later; rdata is meaningless whenever rvalid is zero.
  logic [NUM_PORTS-1:0]        req;
  logic [NUM_PORTS-1:0]        we;
  logic [NUM_PORTS*ADDR_W-1:0] addr;
  logic [NUM_PORTS*DATA_W-1:0] wdata;
  logic [NUM_PORTS-1:0]        gnt;
  logic [NUM_PORTS-1:0]        rvalid;
  logic [DATA_W-1:0]           rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/sram_arbiter_bank.sv
// One 256-word SRAM bank with registered read address. Defining
// uselatticeprim maps it onto an iCE40 SB_RAM256x16 block (DATA_W must be 16).
module sram_bank
  import mem_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic               clk,
  input  logic               re,
  input  logic               we,
  input  logic [BANK_AW-1:0] addr,
  input  logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  rdata
);

`ifdef uselatticeprim
  SB_RAM256x16 u_ram (
    .RDATA (rdata),
    .RADDR (addr),
    .RCLK  (clk),
    .RCLKE (1'b1),
    .RE    (re),
    .WADDR (addr),
    .WCLK  (clk),
    .WCLKE (1'b1),
    .WDATA (wdata),
    .WE    (we),
    .MASK  (16'h0000)
  );
`else
  logic [DATA_W-1:0]  mem_q [BANK_WORDS];
  logic [BANK_AW-1:0] raddr_q;
  logic [BANK_AW-1:0] raddr_d;

  // The read address only moves on a read, so the output keeps showing the
  // last word read from this bank.
  always_comb raddr_d = re ? addr : raddr_q;

  always_ff @(posedge clk) begin
    raddr_q <= raddr_d;
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[raddr_q];
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Multi-port SRAM built from 256-word banks, one access per cycle chosen by a
// combinational arbiter. SRAM_ARB_RR_EN selects round-robin, else fixed priority.
module sram_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 512
) (
  input  logic           clk,
  input  logic           reset,
  sram_arbiter_if.slave  bus
);

  localparam int IDX_W      = $clog2(DEPTH);
  localparam int NUM_BANKS  = DEPTH / BANK_WORDS;
  localparam int BANK_SEL_W = clog2_min1(NUM_BANKS);
  localparam int PTR_W      = clog2_min1(NUM_PORTS);

  port_req_t              reqs [NUM_PORTS];
  port_req_t              sel_req;
  logic                   found;
  logic [PTR_W-1:0]       win_idx;
  logic                   grant_valid;
  logic [NUM_PORTS-1:0]   gnt_o;
  logic [IDX_W-1:0]       word_idx;
  logic [BANK_SEL_W-1:0]  bank_sel;
  logic [BANK_AW-1:0]     row;
  logic [DATA_W-1:0]      bank_rdata [NUM_BANKS];
  logic                   unused_req_bits;

  logic [NUM_PORTS-1:0]   rvalid_q, rvalid_d;
  logic [BANK_SEL_W-1:0]  rd_bank_q, rd_bank_d;
  logic                   hold_q, hold_d;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      reqs[p].we    = bus.we[p];
      reqs[p].addr  = REQ_AW_MAX'(bus.addr[p*ADDR_W +: ADDR_W]);
      reqs[p].wdata = REQ_DW_MAX'(bus.wdata[p*DATA_W +: DATA_W]);
    end
  end

`ifdef SRAM_ARB_RR_EN
  logic [PTR_W-1:0] last_q, last_d;
  int               cand;

  // Search starts just after the last winner and wraps around the ports.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = (int'(last_q) + i) % NUM_PORTS;
      if (!found && bus.req[PTR_W'(cand)]) begin
        found   = 1'b1;
        win_idx = PTR_W'(cand);
      end
    end
  end

  always_comb last_d = grant_valid ? win_idx : last_q;

  always_ff @(posedge clk) begin
    if (reset) last_q <= PTR_W'(NUM_PORTS - 1);
    else       last_q <= last_d;
  end
`else
  // Port 0 is the debug writer, so the lowest index must always win.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && bus.req[PTR_W'(i)]) begin
        found   = 1'b1;
        win_idx = PTR_W'(i);
      end
    end
  end
`endif

  assign grant_valid = found & ~reset;

  always_comb begin
    gnt_o = '0;
    if (grant_valid) gnt_o[win_idx] = 1'b1;
  end

  assign sel_req         = reqs[win_idx];
  assign word_idx        = sel_req.addr[IDX_W-1:0];
  assign bank_sel        = BANK_SEL_W'(word_idx >> BANK_AW);
  assign row             = word_idx[BANK_AW-1:0];
  assign unused_req_bits = ^sel_req;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic hit;
    assign hit = grant_valid && (bank_sel == BANK_SEL_W'(b));

    sram_bank #(.DATA_W(DATA_W)) u_bank (
      .clk   (clk),
      .re    (hit & ~sel_req.we),
      .we    (hit & sel_req.we),
      .addr  (row),
      .wdata (DATA_W'(sel_req.wdata)),
      .rdata (bank_rdata[b])
    );
  end

  // The bank select travels with rvalid so the output mux follows the read.
  always_comb begin
    rvalid_d  = (grant_valid && !sel_req.we) ? gnt_o : '0;
    rd_bank_d = (grant_valid && !sel_req.we) ? bank_sel : rd_bank_q;
    hold_d    = hold_q | (grant_valid & ~sel_req.we);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q  <= '0;
      rd_bank_q <= '0;
      hold_q    <= 1'b0;
    end else begin
      rvalid_q  <= rvalid_d;
      rd_bank_q <= rd_bank_d;
      hold_q    <= hold_d;
    end
  end

  // rvalid is masked by reset so a read granted just before reset never completes.
  assign bus.gnt    = gnt_o;
  assign bus.rvalid = rvalid_q & {NUM_PORTS{~reset}};
  assign bus.rdata  = hold_q ? bank_rdata[rd_bank_q] : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: stimulus table, corner sequences and
// a randomized phase, all scored against a spec-level model.
module tb_sram_arbiter;

  localparam int NP    = 4;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 512;

  logic clk;
  logic reset;

  sram_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // model and scoreboard state
  int               n_checks = 0;
  int               n_fail   = 0;
  logic [DW-1:0]    mdl_mem [int];
  int               mdl_last = NP - 1;
  bit               rdata_zero = 1'b0;
  logic [DW-1:0]    exp_q [$];
  int               port_q [$];
  bit               known_q [$];
  int               last_win = -1;

  logic [AW-1:0]    drv_addr  [NP];
  logic [DW-1:0]    drv_wdata [NP];
  logic [NP-1:0]    obs_gnt;
  logic [NP-1:0]    obs_rvalid;
  logic [DW-1:0]    obs_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NP-1:0] onehot(input int p);
    logic [NP-1:0] v;
    v = '0;
    if (p >= 0) v[p] = 1'b1;
    return v;
  endfunction

  // Winner by the written rules: first requester in priority order.
  function automatic int model_pick(input logic [NP-1:0] r);
    for (int k = 0; k < NP; k++) begin
`ifdef SRAM_ARB_RR_EN
      int p = (mdl_last + 1 + k) % NP;
`else
      int p = k;
`endif
      if (r[p]) return p;
    end
    return -1;
  endfunction

  // driver: one clock cycle, entered and left 1 time unit after posedge
  task automatic run_cycle(input logic [NP-1:0] r, input logic [NP-1:0] w, input logic rst);
    int            win;
    int            p;
    int            idx;
    logic [DW-1:0] d;
    bit            known;
    reset   = rst;
    bus.req = r;
    bus.we  = w;
    for (int i = 0; i < NP; i++) begin
      bus.addr[i*AW +: AW]  = drv_addr[i];
      bus.wdata[i*DW +: DW] = drv_wdata[i];
    end
    @(negedge clk);
    obs_gnt    = bus.gnt;
    obs_rvalid = bus.rvalid;
    obs_rdata  = bus.rdata;
    win = rst ? -1 : model_pick(r);
    chk("gnt", obs_gnt, onehot(win));
    if (rst) begin
      chk("rvalid_in_reset", obs_rvalid, '0);
      exp_q.delete();
      port_q.delete();
      known_q.delete();
    end else if (port_q.size() > 0) begin
      p     = port_q.pop_front();
      d     = exp_q.pop_front();
      known = known_q.pop_front();
      chk("rvalid", obs_rvalid, onehot(p));
      if (known) chk("rdata", obs_rdata, d);
    end else begin
      chk("rvalid_idle", obs_rvalid, '0);
      if (rdata_zero) chk("rdata_after_reset", obs_rdata, '0);
    end
    if (rst) begin
      mdl_last   = NP - 1;
      rdata_zero = 1'b1;
    end else if (win >= 0) begin
      mdl_last = win;
      idx = int'(drv_addr[win]) % DEPTH;
      if (w[win]) begin
        mdl_mem[idx] = drv_wdata[win];
      end else begin
        port_q.push_back(win);
        known_q.push_back(mdl_mem.exists(idx));
        exp_q.push_back(mdl_mem.exists(idx) ? mdl_mem[idx] : '0);
        rdata_zero = 1'b0;
      end
    end
    last_win = win;
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [AW-1:0] a, input logic [DW-1:0] d);
    for (int i = 0; i < NP; i++) begin
      drv_addr[i]  = a;
      drv_wdata[i] = d;
    end
  endtask

  typedef struct {
    logic [NP-1:0] req;
    logic [NP-1:0] we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [NP-1:0] egnt;
    logic [NP-1:0] ervalid;
    logic [DW-1:0] erdata;
  } vec_t;

  vec_t vecs [14];

  // random-phase per-port request state
  bit            pend [NP];
  logic [NP-1:0] r_req, r_we;

  initial begin
    for (int i = 0; i < 6; i++) begin
`ifdef SRAM_ARB_RR_EN
      vecs[i] = '{4'b0101, 4'b0101, 16'h0010, 16'h1111, (i % 2 == 0) ? 4'b0001 : 4'b0100, 4'b0000, 16'h0};
`else
      vecs[i] = '{4'b0101, 4'b0101, 16'h0010, 16'h1111, 4'b0001, 4'b0000, 16'h0};
`endif
    end
    vecs[6]  = '{4'b0010, 4'b0010, 16'h0005, 16'h1234, 4'b0010, 4'b0000, 16'h0};
    vecs[7]  = '{4'b0010, 4'b0000, 16'h0005, 16'h0000, 4'b0010, 4'b0000, 16'h0};
    vecs[8]  = '{4'b0010, 4'b0010, 16'h00FF, 16'hAAAA, 4'b0010, 4'b0010, 16'h1234};
    vecs[9]  = '{4'b0010, 4'b0010, 16'h0100, 16'hBBBB, 4'b0010, 4'b0000, 16'h0};
    vecs[10] = '{4'b0010, 4'b0000, 16'h00FF, 16'h0000, 4'b0010, 4'b0000, 16'h0};
    vecs[11] = '{4'b0010, 4'b0000, 16'h0100, 16'h0000, 4'b0010, 4'b0010, 16'hAAAA};
    vecs[12] = '{4'b0010, 4'b0000, 16'h02FF, 16'h0000, 4'b0010, 4'b0010, 16'hBBBB};
    vecs[13] = '{4'b0000, 4'b0000, 16'h0000, 16'h0000, 4'b0000, 4'b0010, 16'hAAAA};

    reset   = 1'b1;
    bus.req = '0;
    bus.we  = '0;
    set_all('0, '0);
    @(posedge clk);
    #1;
    run_cycle('0, '0, 1'b1);
    run_cycle('0, '0, 1'b1);

    // table: contention, single-port write/read, bank boundary and alias
    for (int i = 0; i < 14; i++) begin
      set_all(vecs[i].a, vecs[i].d);
      run_cycle(vecs[i].req, vecs[i].we, 1'b0);
      chk($sformatf("vec%0d_gnt", i), obs_gnt, vecs[i].egnt);
      chk($sformatf("vec%0d_rvalid", i), obs_rvalid, vecs[i].ervalid);
      if (vecs[i].ervalid != '0) chk($sformatf("vec%0d_rdata", i), obs_rdata, vecs[i].erdata);
    end

    // all ports read continuously; a lone port 3 read first parks the pointer at 3
    drv_addr[0] = 16'h0005;
    drv_addr[1] = 16'h00FF;
    drv_addr[2] = 16'h0100;
    drv_addr[3] = 16'h02FF;
    run_cycle(4'b1000, '0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      run_cycle(4'b1111, '0, 1'b0);
`ifdef SRAM_ARB_RR_EN
      chk($sformatf("allrd%0d_gnt", k), obs_gnt, onehot(k % NP));
`else
      chk($sformatf("allrd%0d_gnt", k), obs_gnt, 4'b0001);
`endif
    end
    run_cycle('0, '0, 1'b0);

    // reset asserted the cycle after a read grant
    run_cycle(4'b0100, '0, 1'b0);
    chk("pre_reset_gnt", obs_gnt, 4'b0100);
    run_cycle(4'b0100, '0, 1'b1);
    chk("reset_kills_rvalid", obs_rvalid, '0);
    run_cycle(4'b1111, '0, 1'b1);
    chk("gnt_in_reset", obs_gnt, '0);

    // first grant after release goes to port 0; port 1 then withdraws
    run_cycle(4'b0011, '0, 1'b0);
    chk("post_reset_first_gnt", obs_gnt, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      run_cycle((k < 3) ? 4'b0001 : 4'b0000, '0, 1'b0);
      chk($sformatf("drop%0d_port1", k), {30'b0, obs_gnt[1], obs_rvalid[1]}, 32'h0);
    end

    // randomized traffic with hold-until-granted and occasional withdrawal
    for (int i = 0; i < NP; i++) pend[i] = 1'b0;
    r_req = '0;
    r_we  = '0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (!pend[p] || last_win == p) begin
          pend[p]      = ($urandom_range(0, 99) < 60);
          r_we[p]      = 1'($urandom_range(0, 1));
          drv_addr[p]  = AW'(($urandom_range(0, 1) ? $urandom_range(0, 7) : 248 + $urandom_range(0, 15))
                             + 512 * $urandom_range(0, 3));
          drv_wdata[p] = DW'($urandom);
        end else if ($urandom_range(0, 99) < 5) begin
          pend[p] = 1'b0;
        end
        r_req[p] = pend[p];
      end
      run_cycle(r_req, r_we, 1'b0);
    end
    run_cycle('0, '0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Parametrised multi-port on-chip SRAM with a built-in arbiter. It replaces the fixed two-bank instruction RAM and the always-ready request/ready loopback in the ice40 top level. Up to NUM_PORTS requestors (debug SPI writer, cpu16 instruction fetch, cpu16 data read/write, later DMA or VGA copy) share one single-port-per-cycle RAM built from 256-word banks. Each request is granted in one cycle with a visible grant, and read data returns a fixed one cycle later.

## Interface
- NUM_PORTS, 4: number of requestor ports, 1..8
- ADDR_W, 16: address width of each port
- DATA_W, 16: word width
- DEPTH, 512: words of storage; power of two, multiple of 256, max 4096
- clk  in  1: system clock; all logic on posedge
- reset  in  1: synchronous, active-high
- req  in  NUM_PORTS: per-port access request
- we  in  NUM_PORTS: per-port write (1) / read (0); sampled with req
- addr  in  NUM_PORTS*ADDR_W: port p occupies bits [p*ADDR_W +: ADDR_W]
- wdata  in  NUM_PORTS*DATA_W: port p occupies bits [p*DATA_W +: DATA_W]
- gnt  out  NUM_PORTS: one-hot or zero; combinational; request accepted at the edge where req[p] & gnt[p]
- rvalid  out  NUM_PORTS: one-hot or zero; registered; read data for port p valid this cycle
- rdata  out  DATA_W: shared read data bus; qualified only by rvalid

## Operation
- Each cycle the arbiter selects at most one requesting port. gnt[p]=1 only if req[p]=1. At most one gnt bit is set.
- The granted access is issued to the RAM in that same cycle. Word index is addr[log2(DEPTH)-1:0]; upper bits are ignored, so addresses alias. Chip-select decode stays outside this block.
- Bank = index[log2(DEPTH)-1:8]. Row = index[7:0]. Only the selected bank gets re or we.
- Write: memory updated at the grant edge. No rvalid.
- Read: rvalid[p]=1 and rdata valid for exactly one cycle after the grant edge.
- Ungranted requestors hold req, we, addr and wdata stable until granted. Dropping req before grant is legal and cancels the request.
- Back-to-back: a port that keeps req high after its grant is a new request in the next cycle. With no contention a port gets one access per cycle.
- Read and write to the same address in consecutive cycles: the read sees the earlier write. Only one access happens per cycle, so a same-cycle collision cannot occur.
- Reset:
  - gnt=0 while reset=1.
  - rvalid=0 and rdata=0 at the edge after reset is asserted.
  - Arbitration state returns to its initial value.
  - RAM contents are not cleared.
  - A read granted in the cycle before reset asserts yields no rvalid.

## Timing
- Grant decision is combinational from req and the registered priority state.
- Read latency is 1 cycle from grant edge to rvalid.
- rdata holds its last value when rvalid=0. This is not guaranteed to the consumer.
- Bank output mux select is registered alongside rvalid, so rdata tracks the bank that was read.
- Critical path is req → gnt → address mux → bank address. It must close at 25 MHz on iCE40 with NUM_PORTS=4.

## Configuration
- SRAM_ARB_RR_EN defined: round-robin arbitration.
  - A registered last-grant pointer resets to NUM_PORTS-1, so port 0 wins first.
  - Search order starts at last+1 and wraps modulo NUM_PORTS.
  - The pointer updates only on a cycle with a grant.
- SRAM_ARB_RR_EN undefined: fixed priority, lowest index wins. Port 0 is wired to the debug interface, keeping debug-over-CPU priority. No pointer register exists.

## Structure
- Package mem_pkg holds:
  - BANK_WORDS=256 and BANK_AW=8
  - the clog2-based width helpers
  - a typedef for the per-port request record (we, addr, wdata) used by the top level to pack the bus
- Sub-module sram_bank: 256×DATA_W, one clock, registered read address. It is built as an inferred array, or as SB_RAM256x16 when uselatticeprim is defined. The arbiter instantiates DEPTH/256 of them in a generate loop.

## Test plan
- Single port 1: write 0x1234 to 0x0005, then read 0x0005. Expected: gnt[1] in the same cycle as each req, no rvalid for the write, rvalid[1] one cycle after the read grant with rdata=0x1234.
- Ports 0 and 2 both write every cycle for 6 cycles.
  - RR build: grants alternate 0,2,0,2,0,2.
  - Fixed build: port 0 gets all 6 grants and port 2 gets none.
- All 4 ports read continuously with RR. Expected: grant order 0,1,2,3,0,1…, each rvalid one cycle after its grant, no gnt/rvalid overlap between ports.
- DEPTH=512: write 0xAAAA to 0x00FF and 0xBBBB to 0x0100, then read both back. Expected: no cross-bank corruption. Read 0x02FF and expect 0xAAAA (alias).
- Assert reset in the cycle after a read grant. Expected: rvalid stays 0, gnt=0 throughout reset, and in RR build the first grant after release goes to port 0.
- Port 1 drops req before it is granted while port 0 holds priority. Expected: port 1 gets no grant and no rvalid at any later point.
